// File: rtl/dlx_mem_ctrl.sv
// DLX memory-side stage: turns mr/mw request levels into one req/ack bus transaction.
// Optional access timeout is enabled by defining DLX_MEM_TIMEOUT_EN.
module dlx_mem_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mr,
    input  logic              mw,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t state, state_nxt;
    logic   start, illegal, fin, tmo;

`ifdef DLX_MEM_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Abort on the edge where this cycle would bring the count up to TIMEOUT.
    assign tmo = (state == ACCESS) && !bus_ack
                 && (wait_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (start) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !bus_ack) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    assign busy = (state == ACCESS) || (state == IDLE && (mr ^ mw));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        illegal   = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (mr && mw) begin
                    illegal = 1'b1;
                end else if (mr ^ mw) begin
                    start     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (bus_ack || tmo) begin
                    fin       = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Wait for the request to drop so a held level never re-triggers.
                if (!mr && !mw) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            data_out  <= '0;
            err       <= 1'b0;
        end else begin
            err <= illegal | tmo;
            if (start) begin
                bus_req   <= 1'b1;
                bus_we    <= mw;
                bus_addr  <= address;
                bus_wdata <= wdata;
            end
            if (fin) begin
                bus_req <= 1'b0;
                if (!bus_we) data_out <= bus_ack ? bus_rdata : '1;
            end
        end
    end

endmodule

// File: tb/tb_dlx_mem_ctrl.sv
// Self-checking bench for dlx_mem_ctrl: directed plan items plus randomized transactions.
// Timeout items are exercised when DLX_MEM_TIMEOUT_EN is defined.
module tb_dlx_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mr, mw;
    logic [15:0] address;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] data_out;
    logic        bus_req, bus_we;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        err;

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_data;

    dlx_mem_ctrl #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .mr(mr), .mw(mw),
        .address(address), .wdata(wdata), .busy(busy),
        .data_out(data_out), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One transaction: issue, wait cycles, ack, hold request, release.
    task automatic txn(input bit is_w, input logic [15:0] a,
                       input logic [31:0] d, input int waits,
                       input logic [31:0] rd, input int hold);
        mr = !is_w;
        mw = is_w;
        address = a;
        wdata = d;
        #1 chk("busy_on_req", busy, 1);
        cyc();
        address = 16'($urandom);
        wdata = $urandom;
        for (int w = 0; w <= waits; w++) begin
            chk("req_access", bus_req, 1);
            chk("busy_access", busy, 1);
            chk("addr_stable", bus_addr, a);
            chk("we", bus_we, is_w);
            if (is_w) chk("wdata_stable", bus_wdata, d);
            chk("no_err_access", err, 0);
            if (w == waits) begin
                bus_ack = 1'b1;
                bus_rdata = rd;
            end else begin
                bus_rdata = $urandom;
            end
            cyc();
        end
        bus_ack = 1'b0;
        if (!is_w) exp_data = rd;
        chk("req_done", bus_req, 0);
        chk("busy_done", busy, 0);
        chk("data_out", data_out, exp_data);
        chk("err_done", err, 0);
        for (int h = 0; h < hold; h++) begin
            bus_ack = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
            cyc();
            bus_ack = 1'b0;
            chk("hold_no_req", bus_req, 0);
            chk("hold_busy", busy, 0);
            chk("hold_data", data_out, exp_data);
        end
        mr = 1'b0;
        mw = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = $urandom;
        cyc();
        bus_ack = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_req", bus_req, 0);
        chk("idle_data", data_out, exp_data);
    endtask

    initial begin
        reset = 1'b0;
        mr = 1'b0;
        mw = 1'b0;
        address = '0;
        wdata = '0;
        bus_rdata = '0;
        bus_ack = 1'b0;
        exp_data = '0;
        @(negedge clk);
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_data", data_out, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        cyc();

        txn(0, 16'h0010, 32'h0, 3, 32'hDEADBEEF, 0);
        txn(1, 16'h0020, 32'h12345678, 0, 32'hA5A5A5A5, 0);
        txn(0, 16'h0030, 32'h0, 0, 32'hCAFEF00D, 5);
        txn(0, 16'h0034, 32'h0, 1, 32'h01020304, 0);

        mr = 1'b1;
        mw = 1'b1;
        #1 chk("illegal_busy", busy, 0);
        cyc();
        mr = 1'b0;
        mw = 1'b0;
        chk("illegal_err", err, 1);
        chk("illegal_req", bus_req, 0);
        cyc();
        chk("illegal_err_pulse", err, 0);
        chk("illegal_req2", bus_req, 0);
        chk("illegal_data", data_out, exp_data);

        for (int i = 0; i < 30; i++) begin
            txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom,
                int'($urandom_range(0, 3)), $urandom,
                int'($urandom_range(0, 3)));
        end

        mr = 1'b1;
        address = 16'h0040;
        cyc();
        chk("mid_req", bus_req, 1);
        #2 reset = 1'b0;
        #1 chk("async_drop_req", bus_req, 0);
        chk("async_data", data_out, 0);
        mr = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h55AA55AA;
        cyc();
        reset = 1'b1;
        cyc();
        bus_ack = 1'b0;
        exp_data = '0;
        chk("late_ack_data", data_out, 0);
        chk("late_ack_req", bus_req, 0);
        chk("late_ack_err", err, 0);

`ifdef DLX_MEM_TIMEOUT_EN
        mr = 1'b1;
        address = 16'h0050;
        cyc();
        for (int c = 0; c < 4; c++) begin
            chk("tmo_req_high", bus_req, 1);
            chk("tmo_no_err", err, 0);
            cyc();
        end
        chk("tmo_req_drop", bus_req, 0);
        chk("tmo_err", err, 1);
        chk("tmo_data", data_out, 32'hFFFFFFFF);
        exp_data = 32'hFFFFFFFF;
        mr = 1'b0;
        cyc();
        chk("tmo_err_pulse", err, 0);
        txn(0, 16'h0054, 32'h0, 3, 32'h13579BDF, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
